uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each single-cycle received-word strobe together with its parity and framing error flags into a circular FIFO. It presents the head entry to the bus/CPU side through a valid/ready handshake. It also maintains fill level, an almost-full watermark, a sticky overflow flag and a saturating error counter.

## Interface
Parameters:
- DATA_WIDTH, 8, width of received word; must match the receiver.
- DEPTH, 16, number of entries; power of two, >= 2.
- AFULL_THRESH, 12, almost_full asserts when level >= this value; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- in_data  in  DATA_WIDTH  received word from the receiver.
- in_valid  in  1  one-cycle strobe; in_data and error flags are valid this cycle.
- in_parity_err  in  1  parity error for the word being strobed.
- in_framing_err  in  1  framing error for the word being strobed.
- out_data  out  DATA_WIDTH  head entry data.
- out_perr  out  1  head entry parity error.
- out_ferr  out  1  head entry framing error.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- flush  in  1  synchronous discard of all entries.
- clr_status  in  1  clears overflow and err_cnt.
- level  out  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH.
- almost_full  out  1  level >= AFULL_THRESH.
- overflow  out  1  sticky; a strobed word was dropped.
- err_cnt  out  8  saturating count of accepted words with any error flag.

## Operation
- Storage: DEPTH x (DATA_WIDTH+2) array; write pointer and read pointer of $clog2(DEPTH) bits wrap modulo DEPTH. level is a separate counter.
- pop = out_valid & out_ready.
- push = in_valid & (level < DEPTH | pop). A word strobed while full is accepted only if a pop occurs the same cycle.
- drop = in_valid & ~push. A drop sets overflow and leaves storage, pointers and level unchanged.
- level update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both or neither: unchanged.
- Output gating:
  - out_valid = (level != 0).
  - out_data/out_perr/out_ferr = head entry when out_valid, else all zeros.
- err_cnt increments by 1 on each push with (in_parity_err | in_framing_err). It holds at 255.
- clr_status clears overflow and err_cnt. If a drop or error-push coincides with clr_status, the new event wins: overflow=1, err_cnt=1.
- flush has priority over push and pop in the same cycle. It sets both pointers and level to 0; the strobed word that cycle is discarded without setting overflow. flush does not affect overflow or err_cnt.
- Reset (rst_n low, asynchronous): pointers, level, overflow, err_cnt = 0. Storage array is not reset. All outputs therefore read 0: out_valid=0, out_data/out_perr/out_ferr=0, level=0, almost_full=0, overflow=0, err_cnt=0.
- Reset mid-operation discards all contents immediately. Operation resumes on the first rising edge after deassertion.

## Timing
- Write latency: word strobed at edge N produces out_valid=1 and the head data after edge N (visible cycle N+1). No same-cycle bypass when empty.
- Pop takes effect at the edge where out_valid & out_ready. The next entry (or out_valid=0) is visible after that edge.
- Throughput: one push and one pop per cycle sustained at any level, including full and empty.
- All status outputs (level, almost_full, overflow, err_cnt) are registered and update one edge after the causing event.
- out_valid does not depend combinationally on out_ready. The consumer may hold out_ready high continuously.

## Test plan
- Reset, then strobe 0x41, 0x42, 0x43 with out_ready=0. Required: level=3, head 0x41. Raise out_ready for 3 cycles: out_data 0x41, 0x42, 0x43 in order, then out_valid=0, level=0.
- Fill 16 words 0x00..0x0F, then strobe 0xAA with out_ready=0. Required: level=16, overflow=1, 0xAA absent. Draining yields exactly 0x00..0x0F.
- At level=16, strobe 0x55 with out_ready=1 in the same cycle. Required: level stays 16, overflow=0, 0x55 read last after 0x01..0x0F. This scenario also exercises pointer wrap.
- Strobe words with parity_err=1, then framing_err=1, then both. Required: out_perr/out_ferr track per entry and err_cnt=3. Push 260 error words across drains: err_cnt saturates at 255. clr_status gives err_cnt=0.
- Cross the watermark at 11 -> 12 entries: almost_full goes 0 -> 1 one edge after the 12th push. Assert flush together with a strobe: level=0, out_valid=0, overflow unchanged.
- Assert rst_n low asynchronously mid-clock at level=5. Required: all outputs 0 immediately, before the next edge. After release, a fresh strobe 0x7E appears as the head entry.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: buffers words with their parity/framing flags
// and tracks fill level, almost-full watermark, sticky overflow and a saturating error count.
module uart_rx_fifo #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic                       in_valid,
   input  logic                       in_parity_err,
   input  logic                       in_framing_err,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_perr,
   output logic                       out_ferr,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       flush,
   input  logic                       clr_status,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       almost_full,
   output logic                       overflow,
   output logic [7:0]                 err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] THRESH_L = LW'(AFULL_THRESH);

   logic [DATA_WIDTH+1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [DATA_WIDTH+1:0] head;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic                  err_push;

   assign out_valid   = (level != '0);
   assign almost_full = (level >= THRESH_L);
   assign pop         = out_valid & out_ready;
   assign push        = in_valid & ((level < DEPTH_L) | pop);
   assign drop        = in_valid & ~push;
   assign err_push    = push & ~flush & (in_parity_err | in_framing_err);

   assign head     = mem[rd_ptr];
   assign out_data = out_valid ? head[DATA_WIDTH-1:0] : '0;
   assign out_ferr = out_valid & head[DATA_WIDTH];
   assign out_perr = out_valid & head[DATA_WIDTH+1];

   // Storage is deliberately not reset; out_valid gating hides stale contents.
   always_ff @(posedge clk) begin
      if (push & ~flush) begin
         mem[wr_ptr] <= {in_parity_err, in_framing_err, in_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         err_cnt  <= 8'd0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push & ~pop)      level <= level + LW'(1);
            else if (pop & ~push) level <= level - LW'(1);
         end

         // A fresh drop or error push beats a coincident clr_status.
         if (drop & ~flush)   overflow <= 1'b1;
         else if (clr_status) overflow <= 1'b0;

         if (clr_status)                        err_cnt <= {7'd0, err_push};
         else if (err_push && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_parity_err;
   logic          in_framing_err;
   logic [DW-1:0] out_data;
   logic          out_perr;
   logic          out_ferr;
   logic          out_valid;
   logic          out_ready;
   logic          flush;
   logic          clr_status;
   logic [LW-1:0] level;
   logic          almost_full;
   logic          overflow;
   logic [7:0]    err_cnt;

   int assertCount = 0;
   int failCount   = 0;

   logic [DW+1:0] mq[$];
   int            mOvf;
   int            mErr;

   uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid),
      .in_parity_err(in_parity_err), .in_framing_err(in_framing_err),
      .out_data(out_data), .out_perr(out_perr), .out_ferr(out_ferr),
      .out_valid(out_valid), .out_ready(out_ready),
      .flush(flush), .clr_status(clr_status),
      .level(level), .almost_full(almost_full),
      .overflow(overflow), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      int n;
      n = mq.size();
      checkOutput("level", 32'(level), 32'(n));
      checkOutput("out_valid", 32'(out_valid), 32'(n != 0));
      checkOutput("almost_full", 32'(almost_full), 32'(n >= 12));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("err_cnt", 32'(err_cnt), 32'(mErr));
      checkOutput("out_data", 32'(out_data), (n != 0) ? 32'(mq[0][DW-1:0]) : 32'd0);
      checkOutput("out_perr", 32'(out_perr), (n != 0) ? 32'(mq[0][DW+1]) : 32'd0);
      checkOutput("out_ferr", 32'(out_ferr), (n != 0) ? 32'(mq[0][DW]) : 32'd0);
   endtask

   // Drives one cycle of inputs, advances the model by the same edge, then checks.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic pe, input logic fe,
                                input logic rdy, input logic fl, input logic clr);
      int   n;
      logic doPop;
      logic doPush;
      in_valid = v; in_data = d; in_parity_err = pe; in_framing_err = fe;
      out_ready = rdy; flush = fl; clr_status = clr;
      @(posedge clk);
      #1;
      n      = mq.size();
      doPop  = (n != 0) && rdy;
      doPush = v && ((n < DEPTH) || doPop);
      if (clr) begin
         mOvf = 0;
         mErr = 0;
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (doPop) void'(mq.pop_front());
         if (doPush) mq.push_back({pe, fe, d});
         if (v && !doPush) mOvf = 1;
         if (doPush && (pe || fe)) mErr = (mErr < 255) ? mErr + 1 : 255;
      end
      in_valid = 1'b0; flush = 1'b0; clr_status = 1'b0;
      checkAll();
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
   endtask

   task automatic strobe(input logic [DW-1:0] d, input logic rdy);
      applyStimulus(1'b1, d, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_parity_err = 1'b0; in_framing_err = 1'b0;
      out_ready = 1'b0; flush = 1'b0; clr_status = 1'b0;
      mOvf = 0; mErr = 0;
      #23;
      checkOutput("reset_level", 32'(level), 32'd0);
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkAll();
      rst_n = 1'b1;
      #8;

      // Basic ordering
      strobe(8'h41, 1'b0); strobe(8'h42, 1'b0); strobe(8'h43, 1'b0);
      checkOutput("t1_level", 32'(level), 32'd3);
      checkOutput("t1_head", 32'(out_data), 32'h41);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t1_order", 32'(out_data), 32'(8'h41 + i));
         idle(1'b1);
      end
      checkOutput("t1_empty_valid", 32'(out_valid), 32'd0);
      checkOutput("t1_empty_level", 32'(level), 32'd0);

      // Overflow while full
      for (int i = 0; i < 16; i++) strobe(8'(i), 1'b0);
      strobe(8'hAA, 1'b0);
      checkOutput("t2_level", 32'(level), 32'd16);
      checkOutput("t2_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         checkOutput("t2_drain", 32'(out_data), 32'(i));
         idle(1'b1);
      end
      checkOutput("t2_empty", 32'(out_valid), 32'd0);

      // Push and pop together while full
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) strobe(8'(i), 1'b0);
      strobe(8'h55, 1'b1);
      checkOutput("t3_level", 32'(level), 32'd16);
      checkOutput("t3_overflow", 32'(overflow), 32'd0);
      for (int i = 1; i < 17; i++) begin
         checkOutput("t3_drain", 32'(out_data), (i == 16) ? 32'h55 : 32'(i));
         idle(1'b1);
      end

      // Error flags and saturation
      applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t4_errcnt", 32'(err_cnt), 32'd3);
      checkOutput("t4_perr0", 32'(out_perr), 32'd1);
      checkOutput("t4_ferr0", 32'(out_ferr), 32'd0);
      idle(1'b1);
      checkOutput("t4_perr1", 32'(out_perr), 32'd0);
      checkOutput("t4_ferr1", 32'(out_ferr), 32'd1);
      idle(1'b1);
      checkOutput("t4_both", 32'({out_perr, out_ferr}), 32'd3);
      idle(1'b1);
      for (int i = 0; i < 260; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t4_saturate", 32'(err_cnt), 32'd255);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("t4_clear", 32'(err_cnt), 32'd0);
      idle(1'b1);

      // Watermark crossing and flush with strobe, overflow set beforehand
      for (int i = 0; i < 17; i++) strobe(8'(i + 8'h20), 1'b0);
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t5_flushovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 11; i++) strobe(8'(i), 1'b0);
      checkOutput("t5_af11", 32'(almost_full), 32'd0);
      strobe(8'h0B, 1'b0);
      checkOutput("t5_af12", 32'(almost_full), 32'd1);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("t5_flush_level", 32'(level), 32'd0);
      checkOutput("t5_flush_valid", 32'(out_valid), 32'd0);
      checkOutput("t5_flush_ovf", 32'(overflow), 32'd1);

      // Asynchronous reset mid-cycle
      for (int i = 0; i < 5; i++) strobe(8'(i + 8'h60), 1'b0);
      checkOutput("t6_level5", 32'(level), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      mq.delete(); mOvf = 0; mErr = 0;
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;
      strobe(8'h7E, 1'b0);
      checkOutput("t6_fresh", 32'(out_data), 32'h7E);
      idle(1'b1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 9) == 0),
                       1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) < 45),
                       1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
